// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants (640x480 @ 60 Hz defaults) and position types,
// so the sync generator and the pixel colour stage agree on one raster.
package vga_timing_pkg;

  localparam int POS_W = 10;

  localparam int H_DISPLAY = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;
  localparam int V_DISPLAY = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;

  localparam int SPRITE_SIZE = 16;

  typedef logic [POS_W-1:0] pos_t;

  function automatic int axis_total(input int display, input int front,
                                    input int sync, input int back);
    return display + front + sync + back;
  endfunction

  localparam int H_TOTAL = axis_total(H_DISPLAY, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL = axis_total(V_DISPLAY, V_FRONT, V_SYNC, V_BACK);

endpackage

// File: rtl/vga_sync_gen_if.sv
// Raster position/sync bundle from vga_sync_gen to the pixel colour stage.
// VGA_FRAME_CNT_EN adds the frame_count animation counter.
interface vga_sync_gen_if;
  import vga_timing_pkg::*;

  pos_t hpos;
  pos_t vpos;
  logic hsync;
  logic vsync;
  logic visible;
  logic line_start;
  logic frame_start;
`ifdef VGA_FRAME_CNT_EN
  logic [POS_W-1:0] frame_count;

  modport master (output hpos, vpos, hsync, vsync, visible, line_start,
                         frame_start, frame_count);
  modport slave  (input  hpos, vpos, hsync, vsync, visible, line_start,
                         frame_start, frame_count);
`else
  modport master (output hpos, vpos, hsync, vsync, visible, line_start,
                         frame_start);
  modport slave  (input  hpos, vpos, hsync, vsync, visible, line_start,
                         frame_start);
`endif

endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter plus decode of the value it is
// about to take, so the parent can register sync/active in step with pos.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int DISPLAY = H_DISPLAY,
  parameter int FRONT   = H_FRONT,
  parameter int SYNC    = H_SYNC,
  parameter int BACK    = H_BACK
) (
  input  logic clk,
  input  logic rst_n,
  input  logic step,
  output pos_t pos,
  output logic next_sync,
  output logic next_active,
  output logic wrap
);

  localparam pos_t LAST    = pos_t'(axis_total(DISPLAY, FRONT, SYNC, BACK) - 1);
  localparam pos_t SYNC_LO = pos_t'(DISPLAY + FRONT);
  localparam pos_t SYNC_HI = pos_t'(DISPLAY + FRONT + SYNC);
  localparam pos_t DISP    = pos_t'(DISPLAY);

  pos_t pos_nxt;

  // Anything at or beyond the last position wraps, so a bad value self-heals.
  assign wrap = (pos >= LAST);

  // NOTE: pos_nxt gets a default before the branch so no latch is inferred.
  always_comb begin
    pos_nxt = pos;
    if (step) pos_nxt = wrap ? '0 : pos + pos_t'(1);
  end

  assign next_sync   = (pos_nxt >= SYNC_LO) && (pos_nxt < SYNC_HI);
  assign next_active = (pos_nxt < DISP);

  // NOTE: state is updated with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pos <= LAST;
    else        pos <= pos_nxt;
  end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: positions, sync pulses, active flag and
// line/frame strobes, all registered and cycle-aligned. Optional: VGA_FRAME_CNT_EN.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int H_DISPLAY   = vga_timing_pkg::H_DISPLAY,
  parameter int H_FRONT     = vga_timing_pkg::H_FRONT,
  parameter int H_SYNC      = vga_timing_pkg::H_SYNC,
  parameter int H_BACK      = vga_timing_pkg::H_BACK,
  parameter int V_DISPLAY   = vga_timing_pkg::V_DISPLAY,
  parameter int V_FRONT     = vga_timing_pkg::V_FRONT,
  parameter int V_SYNC      = vga_timing_pkg::V_SYNC,
  parameter int V_BACK      = vga_timing_pkg::V_BACK,
  parameter bit SYNC_ACTIVE = 1'b0
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           pix_en,
  vga_sync_gen_if.master vga
);

  localparam logic SYNC_ON  = SYNC_ACTIVE;
  localparam logic SYNC_OFF = ~SYNC_ACTIVE;

  pos_t h_pos, v_pos;
  logic h_nsync, h_nact, h_wrap;
  logic v_nsync, v_nact, v_wrap;
  logic v_step;
  logic hsync_q, vsync_q, visible_q, line_start_q, frame_start_q;

  // The vertical axis only moves when the horizontal one rolls over.
  assign v_step = pix_en & h_wrap;

  vga_axis_counter #(
    .DISPLAY(H_DISPLAY), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK)
  ) u_h_axis (
    .clk(clk), .rst_n(rst_n), .step(pix_en),
    .pos(h_pos), .next_sync(h_nsync), .next_active(h_nact), .wrap(h_wrap)
  );

  vga_axis_counter #(
    .DISPLAY(V_DISPLAY), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK)
  ) u_v_axis (
    .clk(clk), .rst_n(rst_n), .step(v_step),
    .pos(v_pos), .next_sync(v_nsync), .next_active(v_nact), .wrap(v_wrap)
  );

  // Decodes follow the counters' next values, so with pix_en low they hold
  // while the strobes (driven from this edge's advance) still drop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync_q       <= SYNC_OFF;
      vsync_q       <= SYNC_OFF;
      visible_q     <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      hsync_q       <= h_nsync ? SYNC_ON : SYNC_OFF;
      vsync_q       <= v_nsync ? SYNC_ON : SYNC_OFF;
      visible_q     <= h_nact & v_nact;
      line_start_q  <= v_step;
      frame_start_q <= v_step & v_wrap;
    end
  end

  assign vga.hpos        = h_pos;
  assign vga.vpos        = v_pos;
  assign vga.hsync       = hsync_q;
  assign vga.vsync       = vsync_q;
  assign vga.visible     = visible_q;
  assign vga.line_start  = line_start_q;
  assign vga.frame_start = frame_start_q;

`ifdef VGA_FRAME_CNT_EN
  logic [POS_W-1:0] frame_cnt_q;

  // Bumps on the same edge that raises frame_start; wraps naturally at 1023.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     frame_cnt_q <= '0;
    else if (v_step & v_wrap)       frame_cnt_q <= frame_cnt_q + 10'd1;
  end

  assign vga.frame_count = frame_cnt_q;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Self-checking bench for vga_sync_gen: a full-size 640x480 instance and a tiny
// 8x5 instance, both tracked by a linear-pixel-index reference model.
module tb_vga_sync_gen;
  import vga_timing_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic pix_en;

  int n_checks = 0;
  int n_err    = 0;
  bit mon_en   = 1'b0;

  always #5 clk = ~clk;

  vga_sync_gen_if std_if ();
  vga_sync_gen_if small_if ();

  vga_sync_gen u_std (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .vga(std_if)
  );

  vga_sync_gen #(
    .H_DISPLAY(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_DISPLAY(2), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .SYNC_ACTIVE(1'b0)
  ) u_small (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .vga(small_if)
  );

  // Reference model: the raster is a single pixel index walking 0..HT*VT-1.
  typedef struct {
    int hd, hf, hs, hb, vd, vf, vs, vb;
    int idx;
    bit adv;
    int fcnt;
  } model_t;

  model_t std_m   = '{hd:640, hf:16, hs:96, hb:48, vd:480, vf:10, vs:2, vb:33,
                      idx:0, adv:1'b0, fcnt:0};
  model_t small_m = '{hd:4, hf:1, hs:2, hb:1, vd:2, vf:1, vs:1, vb:1,
                      idx:0, adv:1'b0, fcnt:0};

  function automatic int m_pixels(input model_t m);
    return (m.hd + m.hf + m.hs + m.hb) * (m.vd + m.vf + m.vs + m.vb);
  endfunction

  function automatic model_t m_reset(input model_t m);
    m.idx  = m_pixels(m) - 1;
    m.adv  = 1'b0;
    m.fcnt = 0;
    return m;
  endfunction

  function automatic model_t m_step(input model_t m, input logic pe);
    m.adv = pe;
    if (pe) begin
      m.idx = (m.idx + 1) % m_pixels(m);
      if (m.idx == 0) m.fcnt = (m.fcnt + 1) % 1024;
    end
    return m;
  endfunction

  function automatic logic [34:0] m_expect(input model_t m);
    int   ht;
    int   h;
    int   v;
    logic hs_n, vs_n, vis, ls, fs;
    logic [9:0] fc;
    ht   = m.hd + m.hf + m.hs + m.hb;
    h    = m.idx % ht;
    v    = m.idx / ht;
    hs_n = !((h >= m.hd + m.hf) && (h < m.hd + m.hf + m.hs));
    vs_n = !((v >= m.vd + m.vf) && (v < m.vd + m.vf + m.vs));
    vis  = (h < m.hd) && (v < m.vd);
    ls   = m.adv && (h == 0);
    fs   = m.adv && (m.idx == 0);
`ifdef VGA_FRAME_CNT_EN
    fc   = 10'(m.fcnt);
`else
    fc   = 10'd0;
`endif
    return {10'(h), 10'(v), hs_n, vs_n, vis, ls, fs, fc};
  endfunction

  function automatic logic [34:0] pack_std();
    logic [9:0] fc;
`ifdef VGA_FRAME_CNT_EN
    fc = std_if.frame_count;
`else
    fc = 10'd0;
`endif
    return {std_if.hpos, std_if.vpos, std_if.hsync, std_if.vsync,
            std_if.visible, std_if.line_start, std_if.frame_start, fc};
  endfunction

  function automatic logic [34:0] pack_small();
    logic [9:0] fc;
`ifdef VGA_FRAME_CNT_EN
    fc = small_if.frame_count;
`else
    fc = 10'd0;
`endif
    return {small_if.hpos, small_if.vpos, small_if.hsync, small_if.vsync,
            small_if.visible, small_if.line_start, small_if.frame_start, fc};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      std_m   <= m_reset(std_m);
      small_m <= m_reset(small_m);
    end else begin
      std_m   <= m_step(std_m, pix_en);
      small_m <= m_step(small_m, pix_en);
    end
  end

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      check("model_std", 64'(pack_std()), 64'(m_expect(std_m)));
      check("model_small", 64'(pack_small()), 64'(m_expect(small_m)));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    pix_en = 1'b0;
    tick();
    tick();
  endtask

  typedef struct {
    logic       rst_n;
    logic       pix_en;
    logic [9:0] hpos;
    logic [9:0] vpos;
    logic       hsync, vsync, visible, ls, fs;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int lo_cnt, lo_first, lo_last, vis_off, found;
    int fs_t[3];
    int fs_n, run, max_run;

    rst_n  = 1'b0;
    pix_en = 1'b0;
    tick();
    tick();
    mon_en = 1'b1;

    // Reset, hold with pix_en low, then the first advances on the full raster.
    tbl[0] = '{1'b0, 1'b1, 10'd799, 10'd524, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 10'd799, 10'd524, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 1'b1, 10'd0,   10'd0,   1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[3] = '{1'b1, 1'b1, 10'd1,   10'd0,   1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{1'b1, 1'b0, 10'd1,   10'd0,   1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 1'b1, 10'd2,   10'd0,   1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 6; i++) begin
      rst_n  = tbl[i].rst_n;
      pix_en = tbl[i].pix_en;
      tick();
      check($sformatf("vec%0d", i),
            64'({std_if.hpos, std_if.vpos, std_if.hsync, std_if.vsync,
                 std_if.visible, std_if.line_start, std_if.frame_start}),
            64'({tbl[i].hpos, tbl[i].vpos, tbl[i].hsync, tbl[i].vsync,
                 tbl[i].visible, tbl[i].ls, tbl[i].fs}));
    end

    // One full line: hsync window and blanking start.
    do_reset();
    rst_n  = 1'b1;
    pix_en = 1'b1;
    lo_cnt = 0; lo_first = -1; lo_last = -1; vis_off = -1;
    for (int c = 0; c < 800; c++) begin
      tick();
      if (std_if.hsync == 1'b0) begin
        lo_cnt++;
        if (lo_first < 0) lo_first = int'(std_if.hpos);
        lo_last = int'(std_if.hpos);
      end
      if (!std_if.visible && vis_off < 0) vis_off = int'(std_if.hpos);
    end
    check("hsync_width", 64'(lo_cnt), 64'd96);
    check("hsync_first", 64'(lo_first), 64'd656);
    check("hsync_last", 64'(lo_last), 64'd751);
    check("blank_start", 64'(vis_off), 64'd640);

    // Reset in the middle of an hsync pulse.
    found = 0;
    for (int c = 0; c < 2000; c++) begin
      tick();
      if (std_if.hpos == 10'd700) begin
        found = 1;
        break;
      end
    end
    check("reach_hpos700", 64'(found), 64'd1);
    check("mid_hsync_on", 64'({std_if.vpos, std_if.hsync}), 64'({10'd1, 1'b0}));
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset",
          64'({std_if.hpos, std_if.vpos, std_if.hsync, std_if.vsync,
               std_if.visible, std_if.line_start, std_if.frame_start}),
          64'({10'd799, 10'd524, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}));
    tick();
    rst_n = 1'b1;
    tick();
    check("post_reset_first",
          64'({std_if.hpos, std_if.vpos, std_if.visible,
               std_if.line_start, std_if.frame_start}),
          64'({10'd0, 10'd0, 1'b1, 1'b1, 1'b1}));

    // Small raster, pix_en tied high: frame period and vsync width.
    do_reset();
    rst_n  = 1'b1;
    pix_en = 1'b1;
    fs_n = 0; lo_cnt = 0;
    for (int c = 0; c < 200 && fs_n < 3; c++) begin
      tick();
      if (small_if.frame_start) begin
        fs_t[fs_n] = c;
        fs_n++;
      end
      if (c < 40 && small_if.vsync == 1'b0) lo_cnt++;
    end
    check("small_fs_count", 64'(fs_n), 64'd3);
    check("small_fs_first", 64'(fs_t[0]), 64'd0);
    check("small_period", 64'(fs_t[1] - fs_t[0]), 64'd40);
    check("small_vsync_width", 64'(lo_cnt), 64'd8);

    // pix_en alternating: period doubles, strobes stay one clock wide.
    do_reset();
    rst_n = 1'b1;
    fs_n = 0; run = 0; max_run = 0;
    for (int c = 0; c < 400 && fs_n < 3; c++) begin
      pix_en = (c % 2 == 0);
      tick();
      if (small_if.frame_start) begin
        fs_t[fs_n] = c;
        fs_n++;
        run++;
        if (run > max_run) max_run = run;
      end else begin
        run = 0;
      end
    end
    check("toggle_fs_count", 64'(fs_n), 64'd3);
    check("toggle_period", 64'(fs_t[2] - fs_t[1]), 64'd80);
    check("toggle_strobe_width", 64'(max_run), 64'd1);

    // Randomised pix_en; the negedge monitor checks both instances.
    do_reset();
    rst_n = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      pix_en = ($urandom_range(0, 3) != 0);
      tick();
    end

`ifdef VGA_FRAME_CNT_EN
    do_reset();
    rst_n  = 1'b1;
    pix_en = 1'b1;
    fs_n = 0;
    for (int c = 0; c < 1100 * 40; c++) begin
      tick();
      if (small_if.frame_start) begin
        fs_n++;
        if (fs_n == 1023) check("fcnt_1023", 64'(small_if.frame_count), 64'd1023);
        if (fs_n == 1024) begin
          check("fcnt_wrap", 64'(small_if.frame_count), 64'd0);
          break;
        end
      end
    end
    check("fcnt_frames_seen", 64'(fs_n), 64'd1024);
    tick();
    rst_n = 1'b0;
    #1;
    check("fcnt_reset", 64'(std_if.frame_count), 64'd0);
    check("fcnt_reset_small", 64'(small_if.frame_count), 64'd0);
`endif

    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
